neuron_bus_reader: RTL and testbench
====================================

NEURON_BUS_READER -- requirements
Module: neuron_bus_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 21, the shared neuron bus width.
REQ-002 SHALL have parameter DEPTH, default 4, the capture FIFO depth; power of two, at least 2.
REQ-003 SHALL have parameter SETTLE_CYC, default 1, the cycles waited after a drive starts before sampling; range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port bus_data, input, DATA_W bits: the resolved value of the shared tri-state bus.
REQ-007 SHALL have port bus_ctl, input, DATA_W bits: the driver's per-bit enable; a 1 means that bit is driven.
REQ-008 SHALL have port bus_en, input, 1 bit: high while a driver owns the bus.
REQ-009 SHALL have port out_data, output, DATA_W bits: the FIFO head word.
REQ-010 SHALL have port out_valid, output, 1 bit: the FIFO is non-empty.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the head word.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when a capture is dropped.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement the FSM as follows:
- IDLE -> SETTLE when bus_en=1.
- SETTLE counts SETTLE_CYC cycles, then -> SAMPLE.
- SAMPLE lasts 1 cycle, then -> RELEASE.
- RELEASE -> IDLE when bus_en=0.
REQ-015 SHALL, in SAMPLE, capture bus_data AND bus_ctl, so undriven bits become 0.
REQ-016 SHALL abort and return to IDLE, with no capture, if bus_en falls during SETTLE.
REQ-017 SHALL, in SAMPLE, push the captured word to the FIFO only if the FIFO is not full; otherwise drop it and set overflow.
REQ-018 SHALL produce at most one capture per bus_en assertion, however long bus_en stays high.
REQ-019 SHALL have a latency of SETTLE_CYC+2 cycles from bus_en rising to out_valid, when the FIFO is empty.
REQ-020 SHALL pop the FIFO when out_valid AND out_ready.
REQ-021 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on a simultaneous push and pop, perform both and leave the count unchanged; a push into a full FIFO with a same-cycle pop SHALL succeed.
REQ-023 SHALL use read and write pointers of log2(DEPTH)+1 bits that wrap modulo 2*DEPTH:
- full when the MSBs differ and the remaining bits are equal;
- empty when the pointers are equal.
REQ-024 SHALL clear overflow only by reset.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, set:
- state IDLE, pointers 0, settle counter 0;
- out_valid=0, overflow=0, busy=0;
- out_data=0.
REQ-026 SHALL, on reset mid-capture, discard the in-flight sample and all FIFO contents.
REQ-027 SHALL, after reset release with bus_en already high, start in SETTLE on the first clock.

Configuration
REQ-028 SHALL, with NEURON_BUS_READER_DROPCNT_EN defined, add output drop_cnt, 8 bits, counting dropped captures; it saturates at 255 and resets to 0.
REQ-029 SHALL, without NEURON_BUS_READER_DROPCNT_EN, have no drop_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-030 SHALL take the FSM state enum (IDLE, SETTLE, SAMPLE, RELEASE) and the default DATA_W from shared package neuron_bus_pkg.
REQ-031 SHALL place the FIFO in sub-module neuron_bus_fifo (parameters DATA_W and DEPTH; push/pop/full/empty interface); the FSM stays in the top.

Verification
REQ-032 SHALL cover full drive: bus_ctl=all ones, bus_data=32, bus_en high for 5 cycles -> one word, out_data=32, out_valid at cycle 3 (SETTLE_CYC=1).
REQ-033 SHALL cover partial drive: bus_ctl=1, bus_data=64 -> out_data=0; then bus_ctl=1, bus_data=65 -> out_data=1.
REQ-034 SHALL cover overflow: 5 captures with out_ready=0 (DEPTH=4) -> 4 words held, overflow=1, drop_cnt=1 (macro on); draining yields the first 4 values in order.
REQ-035 SHALL cover abort: SETTLE_CYC=3, bus_en high for 2 cycles -> no capture; busy returns to 0.
REQ-036 SHALL cover simultaneous push and pop: FIFO full with out_ready=1 during SAMPLE -> count stays 4, overflow stays 0.
REQ-037 SHALL cover reset mid-operation: rst_n low for 1 cycle with 2 words queued and state SETTLE -> out_valid=0, busy=0 next cycle, overflow=0.

Source files
------------

// File: rtl/neuron_bus_pkg.sv
// Shared types for the neuron bus reader: capture FSM states and default bus width.
package neuron_bus_pkg;

  localparam int NB_DATA_W = 21;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    SAMPLE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/neuron_bus_fifo.sv
// Capture FIFO for the neuron bus reader; extra pointer MSB separates full from empty.
module neuron_bus_fifo #(
  parameter int DATA_W = 21,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr, rptr;
  logic              do_push, do_pop;

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/neuron_bus_reader.sv
// Samples a shared tri-state neuron bus once per driver ownership and queues the word.
// Optional drop counter output enabled by NEURON_BUS_READER_DROPCNT_EN.
module neuron_bus_reader
  import neuron_bus_pkg::*;
#(
  parameter int DATA_W     = NB_DATA_W,
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_data,
  input  logic [DATA_W-1:0] bus_ctl,
  input  logic              bus_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              busy
`ifdef NEURON_BUS_READER_DROPCNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t      state;
  logic [3:0]  settle_cnt;
  logic        full, empty, push, pop, drop;

  assign out_valid = !empty;
  assign pop       = !empty && out_ready;
  assign push      = (state == SAMPLE);
  assign drop      = push && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      unique case (state)
        IDLE: if (bus_en) begin
          state      <= SETTLE;
          settle_cnt <= '0;
          busy       <= 1'b1;
        end
        // Driver releasing early means the bus never settled: abort without capture.
        SETTLE: if (!bus_en) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (settle_cnt == SETTLE_LAST) begin
          state <= SAMPLE;
        end else begin
          settle_cnt <= settle_cnt + 1'b1;
        end
        SAMPLE: state <= RELEASE;
        RELEASE: if (!bus_en) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef NEURON_BUS_READER_DROPCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                        drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
  end
`endif

  neuron_bus_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (bus_data & bus_ctl),
    .pop   (pop),
    .rdata (out_data),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_neuron_bus_reader.sv
// Directed bench for neuron_bus_reader: SETTLE_CYC=1 instance plus a SETTLE_CYC=3 instance.
module tb_neuron_bus_reader;
  localparam int W = 21;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] bus_data, bus_ctl;
  logic         bus_en, out_ready, b_en, b_ready;
  logic [W-1:0] out_data, b_data;
  logic         out_valid, overflow, busy, b_valid, b_ovf, b_busy;
  logic [W-1:0] ones;
`ifdef NEURON_BUS_READER_DROPCNT_EN
  logic [7:0]   drop_cnt, b_drop;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  neuron_bus_reader #(.DATA_W(W), .DEPTH(4), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus_data(bus_data), .bus_ctl(bus_ctl), .bus_en(bus_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .busy(busy)
`ifdef NEURON_BUS_READER_DROPCNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  neuron_bus_reader #(.DATA_W(W), .DEPTH(4), .SETTLE_CYC(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus_data(bus_data), .bus_ctl(bus_ctl), .bus_en(b_en),
    .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready),
    .overflow(b_ovf), .busy(b_busy)
`ifdef NEURON_BUS_READER_DROPCNT_EN
    , .drop_cnt(b_drop)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full ownership on dut: SETTLE, SAMPLE (push at 3rd edge), RELEASE, back to IDLE.
  task automatic cap(input logic [W-1:0] d, input logic [W-1:0] c);
    bus_data = d; bus_ctl = c; bus_en = 1'b1;
    tick(); tick(); tick();
    bus_en = 1'b0;
    tick();
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
    n_chk++; if (b_busy !== 1'b0 || b_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b got busy %b valid %b want 0 0", b_busy, b_valid); end
`ifdef NEURON_BUS_READER_DROPCNT_EN
    n_chk++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_dropcnt got %0d want 0", drop_cnt); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_drive();
    bus_data = W'(32); bus_ctl = ones; bus_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_chk++; if (out_valid !== (k >= 3)) begin n_fail++; $display("FAIL full_lat_c%0d got %b want %b", k, out_valid, (k >= 3)); end
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_c%0d got %b want 1", k, busy); end
    end
    n_chk++; if (out_data !== W'(32)) begin n_fail++; $display("FAIL full_data got %h want %h", out_data, W'(32)); end
    bus_en = 1'b0;
    tick();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_release got %b want 0", busy); end
    pop1();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_one_word got valid %b want 0", out_valid); end
  endtask

  task automatic test_partial();
    cap(W'(64), W'(1));
    n_chk++; if (out_valid !== 1'b1 || out_data !== W'(0)) begin n_fail++; $display("FAIL partial_64 got v%b %h want v1 0", out_valid, out_data); end
    pop1();
    cap(W'(65), W'(1));
    n_chk++; if (out_valid !== 1'b1 || out_data !== W'(1)) begin n_fail++; $display("FAIL partial_65 got v%b %h want v1 1", out_valid, out_data); end
    pop1();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL partial_empty got %b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) cap(W'(10 + i), ones);
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before got %b want 0", overflow); end
    cap(W'(14), ones);
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow); end
`ifdef NEURON_BUS_READER_DROPCNT_EN
    n_chk++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_dropcnt got %0d want 1", drop_cnt); end
`endif
    // Hold check: head stays put while the consumer stalls.
    tick(); tick();
    n_chk++; if (out_data !== W'(10)) begin n_fail++; $display("FAIL ovf_hold got %h want %h", out_data, W'(10)); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (out_valid !== 1'b1 || out_data !== W'(10 + i)) begin n_fail++; $display("FAIL ovf_drain%0d got v%b %h want v1 %h", i, out_valid, out_data, W'(10 + i)); end
      pop1();
    end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %b want 0", out_valid); end
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid();
    cap(W'(30), ones);
    cap(W'(31), ones);
    bus_en = 1'b1;
    tick();
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_settle got %b want 1", busy); end
    rst_n = 1'b0;
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_ovf got %b want 0", overflow); end
    rst_n = 1'b1;
    tick();
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_restart got %b want 1", busy); end
    bus_en = 1'b0;
    tick();
    n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_abort got busy %b valid %b want 0 0", busy, out_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) cap(W'(20 + i), ones);
    bus_data = W'(24); bus_ctl = ones; bus_en = 1'b1;
    tick(); tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; bus_en = 1'b0;
    tick();
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf got %b want 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (out_valid !== 1'b1 || out_data !== W'(21 + i)) begin n_fail++; $display("FAIL b2b_drain%0d got v%b %h want v1 %h", i, out_valid, out_data, W'(21 + i)); end
      pop1();
    end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_count got valid %b want 0", out_valid); end
  endtask

  task automatic test_abort();
    bus_data = W'(7); bus_ctl = ones; b_en = 1'b1;
    tick();
    n_chk++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy got %b want 1", b_busy); end
    tick();
    b_en = 1'b0;
    tick();
    n_chk++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle got %b want 0", b_busy); end
    tick(); tick(); tick();
    n_chk++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL abort_nocap got %b want 0", b_valid); end
  endtask

  task automatic test_settle3_latency();
    bus_data = W'(7); bus_ctl = ones; b_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_chk++; if (b_valid !== (k >= 5)) begin n_fail++; $display("FAIL s3_lat_c%0d got %b want %b", k, b_valid, (k >= 5)); end
    end
    n_chk++; if (b_data !== W'(7)) begin n_fail++; $display("FAIL s3_data got %h want %h", b_data, W'(7)); end
    b_en = 1'b0;
    tick();
    n_chk++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL s3_release got %b want 0", b_busy); end
  endtask

  initial begin
    ones = '1;
    rst_n = 1'b0; bus_data = '0; bus_ctl = '0; bus_en = 1'b0; out_ready = 1'b0;
    b_en = 1'b0; b_ready = 1'b0;
    test_reset();
    test_full_drive();
    test_partial();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_abort();
    test_settle3_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
